mux8_arbiter: RTL and testbench



---
 rtl/mux8_arbiter.sv | 124 ++++++++++++
 tb/tb_mux8_arbiter.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/mux8_arbiter.sv
// rtl/mux8_arbiter.sv - 8-input round-robin arbiter driving a shared mux select
// Each owner holds the mux until done, request drop, or the MAX_HOLD limit, whichever comes first.
module mux8_arbiter #(
  parameter int MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic       done,
  output logic [7:0] gnt,
  output logic [2:0] sel,
  output logic       busy,
  output logic       timeout
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD - 1);

  state_t     r_state;
  state_t     w_state_nxt;
  logic [7:0] r_gnt;
  logic [7:0] w_gnt_nxt;
  logic [2:0] r_sel;
  logic [2:0] w_sel_nxt;
  logic [2:0] r_ptr;
  logic [2:0] w_ptr_nxt;
  logic [7:0] r_cnt;
  logic [7:0] w_cnt_nxt;
  logic       r_timeout;
  logic       w_timeout_nxt;

  logic       w_found;
  logic [2:0] w_win;
  logic [2:0] w_idx;
  logic       w_owner_req;
  logic       w_limit;
  logic       w_release;

  // Walk from the farthest offset back to ptr so the closest requester wins.
  always_comb begin
    w_found = 1'b0;
    w_win   = r_ptr;
    w_idx   = r_ptr;
    for (int i = 7; i >= 0; i--) begin
      w_idx = r_ptr + 3'(i);
      if (req[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  assign w_owner_req = req[r_sel];
  assign w_limit     = (r_cnt == HOLD_LIMIT);
  assign w_release   = done | ~w_owner_req | w_limit;

  always_comb begin
    w_state_nxt   = r_state;
    w_gnt_nxt     = r_gnt;
    w_sel_nxt     = r_sel;
    w_ptr_nxt     = r_ptr;
    w_cnt_nxt     = r_cnt;
    w_timeout_nxt = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_state_nxt = ST_GRANT;
          w_gnt_nxt   = 8'b1 << w_win;
          w_sel_nxt   = w_win;
          w_cnt_nxt   = 8'd0;
        end
      end
      ST_GRANT: begin
        if (w_release) begin
          w_state_nxt   = ST_IDLE;
          w_gnt_nxt     = 8'd0;
          w_ptr_nxt     = r_sel + 3'd1;
          // Only flag a forced release; a voluntary one at the limit is not a timeout.
          w_timeout_nxt = w_limit & ~done & w_owner_req;
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_gnt_nxt   = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_gnt     <= 8'd0;
      r_sel     <= 3'd0;
      r_ptr     <= 3'd0;
      r_cnt     <= 8'd0;
      r_timeout <= 1'b0;
    end else begin
      r_gnt     <= w_gnt_nxt;
      r_sel     <= w_sel_nxt;
      r_ptr     <= w_ptr_nxt;
      r_cnt     <= w_cnt_nxt;
      r_timeout <= w_timeout_nxt;
    end
  end

  assign gnt     = r_gnt;
  assign sel     = r_sel;
  assign busy    = (r_state == ST_GRANT);
  assign timeout = r_timeout;

endmodule

// File: tb/tb_mux8_arbiter.sv
// tb/tb_mux8_arbiter.sv - directed self-checking bench for mux8_arbiter
module tb_mux8_arbiter;

  logic       clk;
  logic       rst;
  logic [7:0] req;
  logic       done;
  logic [7:0] gnt;
  logic [2:0] sel;
  logic       busy;
  logic       timeout;

  logic       rst1;
  logic [7:0] req1;
  logic       done1;
  logic [7:0] gnt1;
  logic [2:0] sel1;
  logic       busy1;
  logic       timeout1;

  int n_pass;
  int n_total;

  mux8_arbiter #(.MAX_HOLD(16)) u_dut16 (
    .clk(clk), .rst(rst), .req(req), .done(done),
    .gnt(gnt), .sel(sel), .busy(busy), .timeout(timeout)
  );

  mux8_arbiter #(.MAX_HOLD(1)) u_dut1 (
    .clk(clk), .rst(rst1), .req(req1), .done(done1),
    .gnt(gnt1), .sel(sel1), .busy(busy1), .timeout(timeout1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_total);
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; rst1 = 1'b1; req = 8'h00; done = 1'b0; req1 = 8'h00; done1 = 1'b0;
    #1;
    n_total++; if ({gnt, sel, busy, timeout} !== 13'd0) $display("FAIL reset_outputs: got gnt=%h sel=%0d busy=%b to=%b, need 0", gnt, sel, busy, timeout); else n_pass++;
    n_total++; if ({gnt1, sel1, busy1, timeout1} !== 13'd0) $display("FAIL reset_outputs_mh1: got gnt=%h sel=%0d busy=%b to=%b, need 0", gnt1, sel1, busy1, timeout1); else n_pass++;
    tick();
    tick();
    rst = 1'b0; rst1 = 1'b0;
    tick();
    n_total++; if (gnt !== 8'h00) $display("FAIL idle_no_req: gnt=%h need 00", gnt); else n_pass++;
  endtask

  task automatic test_timeout;
    req = 8'h01;
    tick();
    n_total++; if (gnt !== 8'h01 || sel !== 3'd0 || busy !== 1'b1) $display("FAIL to_grant: gnt=%h sel=%0d busy=%b need 01/0/1", gnt, sel, busy); else n_pass++;
    repeat (15) tick();
    n_total++; if (gnt !== 8'h01 || timeout !== 1'b0) $display("FAIL to_hold16: gnt=%h to=%b need 01/0", gnt, timeout); else n_pass++;
    tick();
    n_total++; if (gnt !== 8'h00 || timeout !== 1'b1 || busy !== 1'b0) $display("FAIL to_release: gnt=%h to=%b busy=%b need 00/1/0", gnt, timeout, busy); else n_pass++;
    req = 8'h03;
    tick();
    n_total++; if (gnt !== 8'h02 || sel !== 3'd1 || timeout !== 1'b0) $display("FAIL to_ptr1: gnt=%h sel=%0d to=%b need 02/1/0", gnt, sel, timeout); else n_pass++;
    done = 1'b1;
    tick();
    n_total++; if (gnt !== 8'h00 || timeout !== 1'b0) $display("FAIL to_done_release: gnt=%h to=%b need 00/0", gnt, timeout); else n_pass++;
    done = 1'b0; req = 8'h00;
    tick();
  endtask

  task automatic test_round_robin;
    logic [7:0] exp_gnt;
    rst = 1'b1; #1; rst = 1'b0;
    req = 8'hFF;
    for (int k = 0; k < 9; k++) begin
      exp_gnt = 8'h01 << (k % 8);
      tick();
      n_total++; if (gnt !== exp_gnt || sel !== 3'(k % 8)) $display("FAIL rr_grant_%0d: gnt=%h sel=%0d need %h/%0d", k, gnt, sel, exp_gnt, k % 8); else n_pass++;
      done = 1'b1;
      tick();
      n_total++; if (gnt !== 8'h00 || busy !== 1'b0 || timeout !== 1'b0) $display("FAIL rr_gap_%0d: gnt=%h busy=%b to=%b need 00/0/0", k, gnt, busy, timeout); else n_pass++;
      done = 1'b0;
    end
    req = 8'h00;
    tick();
  endtask

  task automatic test_wrap;
    rst = 1'b1; #1; rst = 1'b0;
    req = 8'h40;
    tick();
    n_total++; if (gnt !== 8'h40) $display("FAIL wrap_setup: gnt=%h need 40", gnt); else n_pass++;
    done = 1'b1; req = 8'h81;
    tick();
    done = 1'b0;
    tick();
    n_total++; if (gnt !== 8'h80 || sel !== 3'd7) $display("FAIL wrap_h: gnt=%h sel=%0d need 80/7", gnt, sel); else n_pass++;
    done = 1'b1;
    tick();
    n_total++; if (gnt !== 8'h00 || sel !== 3'd7) $display("FAIL wrap_sel_kept: gnt=%h sel=%0d need 00/7", gnt, sel); else n_pass++;
    done = 1'b0;
    tick();
    n_total++; if (gnt !== 8'h01 || sel !== 3'd0) $display("FAIL wrap_a: gnt=%h sel=%0d need 01/0", gnt, sel); else n_pass++;
    done = 1'b1;
    tick();
    done = 1'b0; req = 8'h00;
    tick();
  endtask

  task automatic test_req_drop;
    rst = 1'b1; #1; rst = 1'b0;
    req = 8'h08;
    tick();
    n_total++; if (gnt !== 8'h08 || sel !== 3'd3) $display("FAIL drop_grant3: gnt=%h sel=%0d need 08/3", gnt, sel); else n_pass++;
    req = 8'h28;
    tick();
    n_total++; if (gnt !== 8'h08 || sel !== 3'd3) $display("FAIL drop_nonowner_ignored: gnt=%h sel=%0d need 08/3", gnt, sel); else n_pass++;
    req = 8'h20;
    tick();
    n_total++; if (gnt !== 8'h00 || timeout !== 1'b0) $display("FAIL drop_release: gnt=%h to=%b need 00/0", gnt, timeout); else n_pass++;
    tick();
    n_total++; if (gnt !== 8'h20 || sel !== 3'd5) $display("FAIL drop_next5: gnt=%h sel=%0d need 20/5", gnt, sel); else n_pass++;
    req = 8'h00;
    tick();
    n_total++; if (gnt !== 8'h00 || timeout !== 1'b0) $display("FAIL drop_release5: gnt=%h to=%b need 00/0", gnt, timeout); else n_pass++;
  endtask

  task automatic test_async_reset;
    req = 8'h02;
    tick();
    n_total++; if (gnt !== 8'h02 || sel !== 3'd1) $display("FAIL ar_grant1: gnt=%h sel=%0d need 02/1", gnt, sel); else n_pass++;
    #2 rst = 1'b1;
    #1;
    n_total++; if (gnt !== 8'h00 || sel !== 3'd0 || busy !== 1'b0) $display("FAIL ar_async_clear: gnt=%h sel=%0d busy=%b need 00/0/0", gnt, sel, busy); else n_pass++;
    tick();
    rst = 1'b0; req = 8'h04;
    tick();
    n_total++; if (gnt !== 8'h04 || sel !== 3'd2) $display("FAIL ar_regrant: gnt=%h sel=%0d need 04/2", gnt, sel); else n_pass++;
    req = 8'h00;
    tick();
  endtask

  task automatic test_max_hold_one;
    req1 = 8'h03;
    tick();
    n_total++; if (gnt1 !== 8'h01 || timeout1 !== 1'b0) $display("FAIL mh1_a: gnt=%h to=%b need 01/0", gnt1, timeout1); else n_pass++;
    tick();
    n_total++; if (gnt1 !== 8'h00 || timeout1 !== 1'b1) $display("FAIL mh1_to_a: gnt=%h to=%b need 00/1", gnt1, timeout1); else n_pass++;
    tick();
    n_total++; if (gnt1 !== 8'h02 || sel1 !== 3'd1 || timeout1 !== 1'b0) $display("FAIL mh1_b: gnt=%h sel=%0d to=%b need 02/1/0", gnt1, sel1, timeout1); else n_pass++;
    tick();
    n_total++; if (gnt1 !== 8'h00 || timeout1 !== 1'b1) $display("FAIL mh1_to_b: gnt=%h to=%b need 00/1", gnt1, timeout1); else n_pass++;
    tick();
    n_total++; if (gnt1 !== 8'h01 || sel1 !== 3'd0) $display("FAIL mh1_a2: gnt=%h sel=%0d need 01/0", gnt1, sel1); else n_pass++;
    done1 = 1'b1;
    tick();
    n_total++; if (gnt1 !== 8'h00 || timeout1 !== 1'b0) $display("FAIL mh1_done_no_to: gnt=%h to=%b need 00/0", gnt1, timeout1); else n_pass++;
    tick();
    n_total++; if (gnt1 !== 8'h02 || busy1 !== 1'b1) $display("FAIL mh1_done_idle_ignored: gnt=%h busy=%b need 02/1", gnt1, busy1); else n_pass++;
    done1 = 1'b0; req1 = 8'h00;
    tick();
    n_total++; if (gnt1 !== 8'h00 || timeout1 !== 1'b0) $display("FAIL mh1_end: gnt=%h to=%b need 00/0", gnt1, timeout1); else n_pass++;
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    test_reset();
    test_timeout();
    test_round_robin();
    test_wrap();
    test_req_drop();
    test_async_reset();
    test_max_hold_one();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
